warp_fetch_sequencer: RTL and testbench

Fetch-side partner of the instruction buffer/scoreboard. Captures the one-cycle fetch request and warp mask that the buffer issues. For each requested warp that is active, in ascending warp order, it reads one 32-bit instruction from instruction memory at that warp's PC. It streams the results toward the decoder as warp-tagged beats, with tlast marking the final beat of the burst. It also owns the per-warp PC table, which is updated by sequential advance and by branch/launch writes.

---
 rtl/warp_fetch_sequencer_pkg.sv | 16 +
 rtl/find_first_set32.sv | 17 +
 rtl/warp_fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_warp_fetch_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/warp_fetch_sequencer_pkg.sv
// rtl/warp_fetch_sequencer_pkg.sv - shared error codes and fetch FSM states
package warp_fetch_sequencer_pkg;

  localparam logic [7:0] KIANA_SP_ERR_NONE                 = 8'h00;
  localparam logic [7:0] KIANA_SP_ERR_FETCH_UNEXPECTED_RSP = 8'h31;
  localparam logic [7:0] KIANA_SP_ERR_FETCH_REQ_WHILE_BUSY = 8'h32;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_PEND,
    FS_REQ,
    FS_WAIT,
    FS_OUT
  } fetch_state_e;

endpackage

// File: rtl/find_first_set32.sv
// rtl/find_first_set32.sv - lowest-set-bit encoder for a 32-bit vector
module find_first_set32 (
  input  logic [31:0] vec,
  output logic [4:0]  idx,
  output logic        found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = |vec;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
  end

endmodule

// File: rtl/warp_fetch_sequencer.sv
// rtl/warp_fetch_sequencer.sv - per-warp instruction fetch and decoder stream
module warp_fetch_sequencer
  import warp_fetch_sequencer_pkg::*;
#(
  parameter int NUM_WARPS = 32,
  parameter int PC_STEP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        s_tready_ib,
  input  logic        s_tvalid_ib,
  input  logic [31:0] fetch_mask,
  input  logic [31:0] warp_active,
  input  logic        pc_wr_valid,
  input  logic [4:0]  pc_wr_warp,
  input  logic [31:0] pc_wr_value,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        m_tvalid_dec,
  input  logic        m_tready_dec,
  output logic [4:0]  m_warp_id,
  output logic [31:0] m_instr,
  output logic [31:0] m_pc,
  output logic        m_tlast_dec,
  output logic [7:0]  err
);

  fetch_state_e state, state_next;

  logic [31:0] req_mask;
  logic [31:0] remain;
  logic [31:0] remain_next;
  logic [31:0] snap;
  logic [31:0] cur_onehot;
  logic [4:0]  cur;
  logic [31:0] cur_pc;
  logic [31:0] cur_pc_load;
  logic [4:0]  ffs_idx;
  logic        ffs_found;
  logic        out_hs;
  logic [31:0] pc_table [NUM_WARPS];

  assign snap       = req_mask & warp_active;
  assign cur_onehot = 32'd1 << cur;
  assign out_hs     = (state == FS_OUT) && m_tready_dec;

  // Picks the next warp from the mask remain is about to take.
  find_first_set32 u_ffs (
    .vec   (remain_next),
    .idx   (ffs_idx),
    .found (ffs_found)
  );

  // A PC write landing on the very cycle the next warp is chosen must be seen.
  assign cur_pc_load = (pc_wr_valid && (pc_wr_warp == ffs_idx)) ? pc_wr_value
                                                                : pc_table[ffs_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FS_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    remain_next    = remain;
    s_tready_ib    = (state == FS_IDLE);
    imem_req_valid = (state == FS_REQ);
    m_tvalid_dec   = (state == FS_OUT);
    case (state)
      FS_IDLE: if (s_tvalid_ib) state_next = FS_PEND;
      FS_PEND: begin
        remain_next = snap;
        if (ffs_found) state_next = FS_REQ;
      end
      FS_REQ:  if (imem_req_ready) state_next = FS_WAIT;
      FS_WAIT: if (imem_rsp_valid) state_next = FS_OUT;
      FS_OUT: begin
        if (m_tready_dec) begin
          remain_next = remain & ~cur_onehot;
          state_next  = m_tlast_dec ? FS_IDLE : FS_REQ;
        end
      end
      default: state_next = FS_IDLE;
    endcase
  end

  assign imem_req_addr = cur_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_mask    <= '0;
      remain      <= '0;
      cur         <= '0;
      cur_pc      <= '0;
      m_warp_id   <= '0;
      m_instr     <= '0;
      m_pc        <= '0;
      m_tlast_dec <= 1'b0;
      err         <= KIANA_SP_ERR_NONE;
    end else begin
      if ((state == FS_IDLE) && s_tvalid_ib) req_mask <= fetch_mask;
      remain <= remain_next;
      if ((state_next == FS_REQ) && (state != FS_REQ)) begin
        cur    <= ffs_idx;
        cur_pc <= cur_pc_load;
      end
      if ((state == FS_WAIT) && imem_rsp_valid) begin
        m_instr     <= imem_rsp_data;
        m_pc        <= cur_pc;
        m_warp_id   <= cur;
        m_tlast_dec <= ((remain & ~cur_onehot) == '0);
      end
      if (err == KIANA_SP_ERR_NONE) begin
        if (imem_rsp_valid && (state != FS_WAIT))
          err <= KIANA_SP_ERR_FETCH_UNEXPECTED_RSP;
        else if (s_tvalid_ib && (state != FS_IDLE))
          err <= KIANA_SP_ERR_FETCH_REQ_WHILE_BUSY;
      end
    end
  end

  // Overwrite is written last so it beats the sequential advance on a clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WARPS; i++) pc_table[i] <= '0;
    end else begin
      if (out_hs) pc_table[cur] <= pc_table[cur] + 32'(PC_STEP);
      if (pc_wr_valid) pc_table[pc_wr_warp] <= pc_wr_value;
    end
  end

endmodule

// File: tb/tb_warp_fetch_sequencer.sv
// tb/tb_warp_fetch_sequencer.sv - directed self-checking bench for warp_fetch_sequencer
module tb_warp_fetch_sequencer;
  import warp_fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tready_ib;
  logic        s_tvalid_ib = 1'b0;
  logic [31:0] fetch_mask = '0;
  logic [31:0] warp_active = '0;
  logic        pc_wr_valid = 1'b0;
  logic [4:0]  pc_wr_warp = '0;
  logic [31:0] pc_wr_value = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        m_tvalid_dec;
  logic        m_tready_dec = 1'b0;
  logic [4:0]  m_warp_id;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_tlast_dec;
  logic [7:0]  err;

  int checks = 0;
  int failures = 0;

  warp_fetch_sequencer #(.NUM_WARPS(32), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tready_ib(s_tready_ib), .s_tvalid_ib(s_tvalid_ib),
    .fetch_mask(fetch_mask), .warp_active(warp_active),
    .pc_wr_valid(pc_wr_valid), .pc_wr_warp(pc_wr_warp), .pc_wr_value(pc_wr_value),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .m_tvalid_dec(m_tvalid_dec),
    .m_tready_dec(m_tready_dec), .m_warp_id(m_warp_id), .m_instr(m_instr),
    .m_pc(m_pc), .m_tlast_dec(m_tlast_dec), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, 32'(s_tready_ib), 32'd1);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_m_tvalid"}, 32'(m_tvalid_dec), 32'd0);
    check({tag, "_m_tlast"}, 32'(m_tlast_dec), 32'd0);
    check({tag, "_m_warp"}, 32'(m_warp_id), 32'd0);
    check({tag, "_m_instr"}, m_instr, 32'd0);
    check({tag, "_m_pc"}, m_pc, 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic pulse(input logic [31:0] mask);
    fetch_mask  = mask;
    s_tvalid_ib = 1'b1;
    @(negedge clk);
    s_tvalid_ib = 1'b0;
  endtask

  task automatic pc_write(input logic [4:0] w, input logic [31:0] v);
    pc_wr_valid = 1'b1; pc_wr_warp = w; pc_wr_value = v;
    @(negedge clk);
    pc_wr_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(imem_req_valid), 32'd1);
  endtask

  // One full beat: request (optionally stalled), response, decoder output
  // (optionally back-pressured), handshake (optionally racing a PC write).
  task automatic beat(input logic [4:0] w, input logic [31:0] addr, input logic [31:0] data,
                      input logic last, input int stall, input int bp,
                      input logic race, input logic [31:0] race_pc);
    wait_req();
    check("req_addr", imem_req_addr, addr);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_req_addr, addr);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < bp; i++) begin
      check("bp_instr", m_instr, data);
      check("bp_pc", m_pc, addr);
      @(negedge clk);
    end
    check("out_valid", 32'(m_tvalid_dec), 32'd1);
    check("out_warp", 32'(m_warp_id), 32'(w));
    check("out_pc", m_pc, addr);
    check("out_instr", m_instr, data);
    check("out_last", 32'(m_tlast_dec), 32'(last));
    m_tready_dec = 1'b1;
    if (race) begin
      pc_wr_valid = 1'b1; pc_wr_warp = w; pc_wr_value = race_pc;
    end
    @(negedge clk);
    m_tready_dec = 1'b0;
    pc_wr_valid  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    warp_active = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) pc_write(5'(i), 32'h100);

    // Basic burst with minimum-latency checks
    pulse(32'h5);
    check("pend_tready", 32'(s_tready_ib), 32'd0);
    check("pend_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    check("lat_req", 32'(imem_req_valid), 32'd1);
    beat(5'd0, 32'h100, 32'hA000_0000, 1'b0, 0, 0, 1'b0, 32'h0);
    beat(5'd2, 32'h100, 32'hA000_0002, 1'b1, 0, 0, 1'b0, 32'h0);
    check("idle_after_last", 32'(s_tready_ib), 32'd1);
    pulse(32'h5);
    beat(5'd0, 32'h104, 32'hB000_0000, 1'b0, 0, 0, 1'b0, 32'h0);
    beat(5'd2, 32'h104, 32'hB000_0002, 1'b1, 0, 0, 1'b0, 32'h0);

    // Inactive filter
    warp_active = 32'h2;
    pulse(32'h3);
    beat(5'd1, 32'h100, 32'hC000_0001, 1'b1, 0, 0, 1'b0, 32'h0);

    // Pending until a warp becomes active
    warp_active = 32'h0;
    pulse(32'h1);
    for (int i = 0; i < 10; i++) begin
      check("pend_no_req", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
    end
    warp_active = 32'h1;
    beat(5'd0, 32'h108, 32'hD000_0000, 1'b1, 0, 0, 1'b0, 32'h0);

    // Backpressure with PC-write race, then memory stall on the result
    warp_active = 32'hFFFF_FFFF;
    pulse(32'h8);
    beat(5'd3, 32'h100, 32'hE000_0003, 1'b1, 0, 5, 1'b1, 32'h800);
    pulse(32'h8);
    beat(5'd3, 32'h800, 32'hE100_0003, 1'b1, 4, 0, 1'b0, 32'h0);

    // Stray response in IDLE, then busy request must not overwrite it
    check("err_clear", 32'(err), 32'd0);
    imem_rsp_valid = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("err_unexp", 32'(err), 32'(KIANA_SP_ERR_FETCH_UNEXPECTED_RSP));
    pulse(32'h1);
    pulse(32'h1);
    beat(5'd0, 32'h10C, 32'hF000_0000, 1'b1, 0, 0, 1'b0, 32'h0);
    check("err_sticky", 32'(err), 32'(KIANA_SP_ERR_FETCH_UNEXPECTED_RSP));

    // Reset mid-burst while a beat is presented
    pulse(32'h5);
    wait_req();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("pre_rst_valid", 32'(m_tvalid_dec), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse(32'h5);
    beat(5'd0, 32'h0, 32'h9000_0000, 1'b0, 0, 0, 1'b0, 32'h0);
    beat(5'd2, 32'h0, 32'h9000_0002, 1'b1, 0, 0, 1'b0, 32'h0);
    pulse(32'h8);
    beat(5'd3, 32'h0, 32'h9000_0003, 1'b1, 0, 0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
